// File: rtl/chroma_block_buffer.sv
// chroma_block_buffer
//   Collects decimated Cb/Cr pairs from the 4:2:0 downsampler into 8x8 blocks
//   held in a two-bank ping-pong store, then replays each full block to the
//   DCT as all Cb samples followed by all Cr samples on a valid/ready stream.
//   Upstream cannot be stalled: in_ready is advisory, and a pair offered while
//   the write bank is still full is dropped and latched into overflow.
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   cb_in, cr_in          sample pair from downsampler
//   valid_in              pair valid this cycle
//   in_ready              write bank free (combinational)
//   out_data              sample to DCT
//   out_comp              0 = Cb, 1 = Cr
//   out_idx               sample index within component block
//   out_sof               first sample of each component block
//   out_eob               last Cr sample of the block
//   out_valid, out_ready  output handshake
//   overflow              sticky dropped-sample flag
module chroma_block_buffer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BLOCK_LEN = 64,
  localparam int unsigned IDX_W    = $clog2(BLOCK_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cb_in,
  input  logic [DATA_W-1:0] cr_in,
  input  logic              valid_in,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_comp,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_sof,
  output logic              out_eob,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {IDLE, EMIT_CB, EMIT_CR} state_t;

  logic [DATA_W-1:0] mem_cb [2][BLOCK_LEN];
  logic [DATA_W-1:0] mem_cr [2][BLOCK_LEN];

  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_bank;
  logic [1:0]       full;
  state_t           state;

  logic             wr_en;
  logic             wr_fill;
  logic [1:0]       set_mask;
  logic [1:0]       clr_mask;

  state_t           state_nx;
  logic             rd_bank_nx;
  logic             rd_free;
  logic [DATA_W-1:0] data_nx;
  logic             comp_nx;
  logic [IDX_W-1:0] idx_nx;
  logic             sof_nx;
  logic             eob_nx;
  logic             valid_nx;
  logic [IDX_W-1:0] idx_inc;
  logic             idx_last;

  assign in_ready = ~full[wr_bank];
  assign wr_en    = valid_in & in_ready;
  assign wr_fill  = wr_en & (wr_idx == LAST_IDX);

  // Fill and free always target different banks, so both can apply on one edge.
  assign set_mask = {wr_fill & wr_bank, wr_fill & ~wr_bank};
  assign clr_mask = {rd_free & rd_bank, rd_free & ~rd_bank};

  assign idx_inc  = out_idx + 1'b1;
  assign idx_last = (out_idx == LAST_IDX);

  // Sample store; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_cb[wr_bank][wr_idx] <= cb_in;
      mem_cr[wr_bank][wr_idx] <= cr_in;
    end
  end

  // Write pointer, bank flags and overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_idx   <= '0;
      full     <= 2'b00;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_fill) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (valid_in && !in_ready) begin
        overflow <= 1'b1;
      end
      full <= (full | set_mask) & ~clr_mask;
    end
  end

  // Read FSM state and registered output stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      out_data  <= '0;
      out_comp  <= 1'b0;
      out_idx   <= '0;
      out_sof   <= 1'b0;
      out_eob   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      rd_bank   <= rd_bank_nx;
      out_data  <= data_nx;
      out_comp  <= comp_nx;
      out_idx   <= idx_nx;
      out_sof   <= sof_nx;
      out_eob   <= eob_nx;
      out_valid <= valid_nx;
    end
  end

  // Next state and next output word; holding everything covers backpressure.
  always_comb begin
    state_nx   = state;
    rd_bank_nx = rd_bank;
    rd_free    = 1'b0;
    data_nx    = out_data;
    comp_nx    = out_comp;
    idx_nx     = out_idx;
    sof_nx     = out_sof;
    eob_nx     = out_eob;
    valid_nx   = out_valid;

    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nx = EMIT_CB;
          data_nx  = mem_cb[rd_bank][0];
          comp_nx  = 1'b0;
          idx_nx   = '0;
          sof_nx   = 1'b1;
          eob_nx   = 1'b0;
          valid_nx = 1'b1;
        end
      end
      EMIT_CB: begin
        if (out_ready) begin
          if (!idx_last) begin
            idx_nx  = idx_inc;
            data_nx = mem_cb[rd_bank][idx_inc];
            sof_nx  = 1'b0;
          end else begin
            state_nx = EMIT_CR;
            data_nx  = mem_cr[rd_bank][0];
            comp_nx  = 1'b1;
            idx_nx   = '0;
            sof_nx   = 1'b1;
          end
        end
      end
      EMIT_CR: begin
        if (out_ready) begin
          if (!idx_last) begin
            idx_nx  = idx_inc;
            data_nx = mem_cr[rd_bank][idx_inc];
            sof_nx  = 1'b0;
            eob_nx  = (idx_inc == LAST_IDX);
          end else begin
            state_nx   = IDLE;
            rd_free    = 1'b1;
            rd_bank_nx = ~rd_bank;
            sof_nx     = 1'b0;
            eob_nx     = 1'b0;
            valid_nx   = 1'b0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chroma_block_buffer.sv
// tb_chroma_block_buffer
//   Directed bench for chroma_block_buffer: fill/emit latency, backpressure
//   hold, two-bank overflow, reset mid-emission and same-edge fill/free.
module tb_chroma_block_buffer;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BLOCK_LEN = 64;
  localparam int unsigned IDX_W     = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] cb_in = '0;
  logic [DATA_W-1:0] cr_in = '0;
  logic              valid_in = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_comp;
  logic [IDX_W-1:0]  out_idx;
  logic              out_sof;
  logic              out_eob;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  chroma_block_buffer #(.DATA_W(DATA_W), .BLOCK_LEN(BLOCK_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .cb_in(cb_in), .cr_in(cr_in),
    .valid_in(valid_in), .in_ready(in_ready), .out_data(out_data),
    .out_comp(out_comp), .out_idx(out_idx), .out_sof(out_sof),
    .out_eob(out_eob), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_block(input logic [7:0] cb_base, input logic [7:0] cr_base);
    for (int i = 0; i < 64; i++) begin
      valid_in = 1'b1;
      cb_in    = cb_base + 8'(i);
      cr_in    = cr_base + 8'(i);
      tick();
    end
    valid_in = 1'b0;
  endtask

  // Expects sample 0 already on the outputs; consumes all 128 samples.
  task automatic receive_block(input logic [7:0] cb_base, input logic [7:0] cr_base,
                               input int stall_at, input string name);
    logic [17:0]      exp_v;
    logic [17:0]      got_v;
    logic             c;
    logic [IDX_W-1:0] ix;
    logic [7:0]       d;
    out_ready = 1'b1;
    for (int k = 0; k < 128; k++) begin
      c  = (k >= 64);
      ix = 6'(k % 64);
      d  = c ? (cr_base + 8'(ix)) : (cb_base + 8'(ix));
      exp_v = {1'b1, c, ix, (ix == 6'd0), (c && ix == 6'd63), d};
      got_v = {out_valid, out_comp, out_idx, out_sof, out_eob, out_data};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s sample %0d: got {v,c,idx,sof,eob,data}=%h expected %h",
                 name, k, got_v, exp_v);
      end
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          tick();
          got_v = {out_valid, out_comp, out_idx, out_sof, out_eob, out_data};
          checks++;
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s hold cycle %0d: got %h expected %h", name, s, got_v, exp_v);
          end
        end
        out_ready = 1'b1;
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || out_eob !== 1'b0) begin
      errors++;
      $display("FAIL %s end: got valid=%b eob=%b expected 0 0", name, out_valid, out_eob);
    end
  endtask

  task automatic test_reset();
    logic [18:0] got_v;
    rst_n = 1'b0;
    tick();
    tick();
    got_v = {out_valid, out_comp, out_idx, out_sof, out_eob, out_data, overflow};
    checks++;
    if (got_v !== 19'd0) begin
      errors++;
      $display("FAIL reset outputs: got %h expected 0", got_v);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %b expected 1", in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    write_block(8'd0, 8'd128);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic latency: out_valid=%b on fill edge, expected 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic in_ready: got %b expected 1", in_ready);
    end
    tick();
    receive_block(8'd0, 8'd128, -1, "basic");
  endtask

  task automatic test_stall();
    write_block(8'd0, 8'd128);
    tick();
    receive_block(8'd0, 8'd128, 20, "stall");
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    write_block(8'd0, 8'd128);
    write_block(8'd64, 8'd192);
    checks++;
    if (in_ready !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf both_full: got in_ready=%b overflow=%b expected 0 0", in_ready, overflow);
    end
    valid_in = 1'b1;
    cb_in    = 8'hAA;
    cr_in    = 8'hBB;
    tick();
    valid_in = 1'b0;
    checks++;
    if (overflow !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf drop: got overflow=%b in_ready=%b expected 1 0", overflow, in_ready);
    end
    receive_block(8'd0, 8'd128, -1, "ovf_bank0");
    checks++;
    if (in_ready !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf after_free: got in_ready=%b overflow=%b expected 1 1", in_ready, overflow);
    end
    tick();
    receive_block(8'd64, 8'd192, -1, "ovf_bank1");
  endtask

  task automatic test_reset_mid();
    logic [18:0] got_v;
    out_ready = 1'b1;
    write_block(8'h10, 8'h90);
    tick();
    // Emit into the Cr block while partially filling the other bank with junk.
    for (int j = 0; j < 74; j++) begin
      valid_in = (j < 10);
      cb_in    = 8'hEE;
      cr_in    = 8'hEE;
      tick();
    end
    valid_in = 1'b0;
    checks++;
    if ({out_valid, out_comp, out_idx, out_data} !== {1'b1, 1'b1, 6'd10, 8'h9A}) begin
      errors++;
      $display("FAIL rstmid position: got v=%b c=%b idx=%0d data=%h expected 1 1 10 9a",
               out_valid, out_comp, out_idx, out_data);
    end
    rst_n = 1'b0;
    #1;
    got_v = {out_valid, out_comp, out_idx, out_sof, out_eob, out_data, overflow};
    checks++;
    if (got_v !== 19'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid async: got outputs=%h in_ready=%b expected 0 1", got_v, in_ready);
    end
    tick();
    rst_n = 1'b1;
    write_block(8'd0, 8'd128);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid latency: out_valid=%b on fill edge, expected 0", out_valid);
    end
    tick();
    receive_block(8'd0, 8'd128, -1, "rstmid_fresh");
  endtask

  task automatic test_same_edge();
    out_ready = 1'b1;
    write_block(8'h20, 8'hA0);
    fork
      begin
        tick();
        receive_block(8'h20, 8'hA0, -1, "same_edge_a");
      end
      begin
        repeat (65) tick();
        write_block(8'h40, 8'hC0);
      end
    join
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_edge in_ready: got %b expected 1", in_ready);
    end
    tick();
    receive_block(8'h40, 8'hC0, -1, "same_edge_b");
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_edge final in_ready: got %b expected 1", in_ready);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_same_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
